slp_layer_ctrl: RTL and testbench

SLP_LAYER_CTRL -- requirements
Module: slp_layer_ctrl

---
 rtl/slp_layer_ctrl.sv | 145 ++++++++++++++
 tb/tb_slp_layer_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slp_layer_ctrl.sv
// Single-layer perceptron controller: runs OUT neurons in turn
// through one shared slp_infer datapath and collects the results.
module slp_layer_ctrl #(
  parameter int IN     = 4,
  parameter int OUT    = 8,
  parameter int I_PREC = 8,
  parameter int W_PREC = 8,
  parameter int O_PREC = 8,
  localparam int NW    = (OUT > 1) ? $clog2(OUT) : 1
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN*I_PREC-1:0]     in_vec,
  output logic                     w_rd,
  output logic [NW-1:0]            w_addr,
  input  logic [(IN+1)*W_PREC-1:0] w_data,
  output logic [IN*I_PREC-1:0]     dp_in,
  output logic [(IN+1)*W_PREC-1:0] dp_weight,
  input  logic [O_PREC-1:0]        dp_out,
  input  logic                     dp_udf,
  input  logic                     dp_ovf,
  input  logic                     dp_rounded,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT*O_PREC-1:0]    out_vec,
  output logic [OUT-1:0]           out_sat,
  output logic [OUT-1:0]           out_rnd,
  output logic                     busy
);

  localparam int IW = IN * I_PREC;
  localparam int WW = (IN + 1) * W_PREC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EVAL,
    S_DONE
  } state_t;

  state_t                       state_q, state_d;
  logic [NW-1:0]                n_q, n_d;
  logic [IW-1:0]                dp_in_q, dp_in_d;
  logic [WW-1:0]                dp_weight_q, dp_weight_d;
  logic [OUT-1:0][O_PREC-1:0]   res_q, res_d;
  logic [OUT-1:0]               sat_q, sat_d;
  logic [OUT-1:0]               rnd_q, rnd_d;
  logic                         in_ready_q, in_ready_d;
  logic                         w_rd_q, w_rd_d;
  logic                         out_valid_q, out_valid_d;
  logic                         busy_q, busy_d;

  // Next-state, datapath capture and registered status outputs.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    dp_in_d     = dp_in_q;
    dp_weight_d = dp_weight_q;
    res_d       = res_q;
    sat_d       = sat_q;
    rnd_d       = rnd_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          dp_in_d = in_vec;
          n_d     = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        dp_weight_d = w_data;
        state_d     = S_EVAL;
      end
      S_EVAL: begin
        for (int k = 0; k < OUT; k++) begin
          if (n_q == NW'(k)) begin
            res_d[k] = dp_out;
            sat_d[k] = dp_udf | dp_ovf;
            rnd_d[k] = dp_rounded;
          end
        end
        if (n_q == NW'(OUT - 1)) begin
          n_d     = '0;
          state_d = S_DONE;
        end else begin
          n_d     = n_q + NW'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    w_rd_d      = (state_d == S_FETCH);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers; reset idles ready for a vector.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      dp_in_q     <= '0;
      dp_weight_q <= '0;
      res_q       <= '0;
      sat_q       <= '0;
      rnd_q       <= '0;
      in_ready_q  <= 1'b1;
      w_rd_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      dp_in_q     <= dp_in_d;
      dp_weight_q <= dp_weight_d;
      res_q       <= res_d;
      sat_q       <= sat_d;
      rnd_q       <= rnd_d;
      in_ready_q  <= in_ready_d;
      w_rd_q      <= w_rd_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign w_rd      = w_rd_q;
  assign w_addr    = n_q;
  assign dp_in     = dp_in_q;
  assign dp_weight = dp_weight_q;
  assign out_valid = out_valid_q;
  assign out_vec   = res_q;
  assign out_sat   = sat_q;
  assign out_rnd   = rnd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_slp_layer_ctrl.sv
// Randomized scoreboard bench for slp_layer_ctrl with a behavioural
// weight memory and slp_infer stand-in.
module tb_slp_layer_ctrl;

  localparam int IN  = 4;
  localparam int OUT = 3;
  localparam int NW  = (OUT > 1) ? $clog2(OUT) : 1;
  localparam int IW  = IN * 8;
  localparam int WW  = (IN + 1) * 8;
  localparam int OW  = OUT * 8;

  typedef struct packed {
    logic [7:0] o;
    logic       udf;
    logic       ovf;
    logic       rnd;
  } nres_t;

  typedef struct {
    logic [OW-1:0]  vec;
    logic [OUT-1:0] sat;
    logic [OUT-1:0] rnd;
    int             acc;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset_;
  logic           in_valid, in_ready;
  logic [IW-1:0]  in_vec;
  logic           w_rd;
  logic [NW-1:0]  w_addr;
  logic [WW-1:0]  w_data;
  logic [IW-1:0]  dp_in;
  logic [WW-1:0]  dp_weight;
  logic [7:0]     dp_out;
  logic           dp_udf, dp_ovf, dp_rounded;
  logic           out_valid, out_ready;
  logic [OW-1:0]  out_vec;
  logic [OUT-1:0] out_sat, out_rnd;
  logic           busy;

  logic [WW-1:0]  wmem [OUT];
  exp_t           q [$];
  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;
  int             wr_cnt = 0;
  int             n_acc = 0;
  int             hs_edge = 0;
  int             rel_edge = 0;
  bit             hs_pending = 0;
  bit             chk_rel = 0;
  bit             b2b = 0;
  bit             expect_idle = 0;
  bit             scramble = 0;
  logic [IW-1:0]  cur_x = '0;
  logic [OW-1:0]  last_vec;
  logic [OUT-1:0] last_sat;
  nres_t          dp_r;

  slp_layer_ctrl #(
    .IN(IN), .OUT(OUT), .I_PREC(8), .W_PREC(8), .O_PREC(8)
  ) dut (
    .clk(clk), .reset_(reset_),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data),
    .dp_in(dp_in), .dp_weight(dp_weight),
    .dp_out(dp_out), .dp_udf(dp_udf), .dp_ovf(dp_ovf),
    .dp_rounded(dp_rounded),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_sat(out_sat), .out_rnd(out_rnd),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Neuron: integer MAC plus bias, ReLU, clamp at 127.
  function automatic nres_t neuron(input logic [IW-1:0] x,
                                   input logic [WW-1:0] w);
    nres_t r;
    int    acc;
    acc = int'($signed(w[IN*8 +: 8]));
    for (int i = 0; i < IN; i++)
      acc += int'($signed(x[i*8 +: 8])) * int'($signed(w[i*8 +: 8]));
    r.rnd = acc[0];
    r.ovf = (acc > 127);
    r.udf = (acc < -128);
    if (acc < 0)      r.o = 8'd0;
    else if (r.ovf)   r.o = 8'd127;
    else              r.o = acc[7:0];
    return r;
  endfunction

  function automatic exp_t layer(input logic [IW-1:0] x);
    exp_t  e;
    nres_t r;
    e.vec = '0; e.sat = '0; e.rnd = '0; e.acc = 0;
    for (int n = 0; n < OUT; n++) begin
      r = neuron(x, wmem[n]);
      e.vec[n*8 +: 8] = r.o;
      e.sat[n] = r.udf | r.ovf;
      e.rnd[n] = r.rnd;
    end
    return e;
  endfunction

  function automatic logic [IW-1:0] rand_x();
    logic [IW-1:0] r;
    for (int i = 0; i < IN; i++) r[i*8 +: 8] = 8'($urandom);
    return r;
  endfunction

  function automatic logic [WW-1:0] rand_w();
    logic [WW-1:0] r;
    for (int i = 0; i <= IN; i++) r[i*8 +: 8] = 8'($urandom);
    return r;
  endfunction

  // Datapath stand-in, combinational from the controller's registers.
  always_comb dp_r = neuron(dp_in, dp_weight);
  assign dp_out     = dp_r.o;
  assign dp_udf     = dp_r.udf;
  assign dp_ovf     = dp_r.ovf;
  assign dp_rounded = dp_r.rnd;

  // Weight memory: row valid the cycle after w_rd, garbage otherwise.
  always @(posedge clk)
    w_data <= w_rd ? wmem[int'(w_addr)] : rand_w();

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_w_rd", 64'(w_rd), 64'd0);
    chk("rst_w_addr", 64'(w_addr), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_vec", 64'(out_vec), 64'd0);
    chk("rst_out_sat", 64'(out_sat), 64'd0);
    chk("rst_out_rnd", 64'(out_rnd), 64'd0);
    chk("rst_dp_in", 64'(dp_in), 64'd0);
    chk("rst_dp_weight", 64'(dp_weight), 64'd0);
  endtask

  // Input monitor: every accepted vector yields one expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_ && in_valid && in_ready) begin
        e = layer(in_vec);
        e.acc = cyc + 1;
        q.push_back(e);
        cur_x = in_vec;
        wr_cnt = 0;
        n_acc++;
        if (hs_pending) begin
          chk("b2b_gap", 64'(e.acc - hs_edge), 64'd1);
          hs_pending = 0;
        end
        if (chk_rel) begin
          chk("accept_after_reset", 64'(e.acc - rel_edge), 64'd1);
          chk_rel = 0;
        end
      end
    end
  end

  // Output monitor: pops expectations and polices the handshakes.
  initial begin
    exp_t e;
    bit   have_e = 0;
    bit   prev_ov = 0;
    bit   prev_wrd = 0;
    forever begin
      @(negedge clk);
      if (!reset_) begin
        prev_ov = 0; prev_wrd = 0; have_e = 0;
        expect_idle = 0; hs_pending = 0;
      end else begin
        if (expect_idle) begin
          chk("idle_out_valid", 64'(out_valid), 64'd0);
          chk("idle_in_ready", 64'(in_ready), 64'd1);
          chk("idle_busy", 64'(busy), 64'd0);
          expect_idle = 0;
        end
        if (busy) begin
          chk("dp_in_hold", 64'(dp_in), 64'(cur_x));
          chk("busy_in_ready", 64'(in_ready), 64'd0);
        end
        if (w_rd) begin
          chk("w_addr", 64'(w_addr), 64'(wr_cnt));
          chk("w_rd_pulse", 64'(prev_wrd), 64'd0);
          wr_cnt++;
        end
        prev_wrd = w_rd;
        if (out_valid) begin
          if (!prev_ov) begin
            if (q.size() == 0) begin
              fail("spurious_out_valid");
            end else begin
              e = q.pop_front();
              have_e = 1;
              chk("latency", 64'(cyc - e.acc), 64'(3 * OUT));
              chk("w_rd_count", 64'(wr_cnt), 64'(OUT));
            end
          end
          if (have_e) begin
            chk("out_vec", 64'(out_vec), 64'(e.vec));
            chk("out_sat", 64'(out_sat), 64'(e.sat));
            chk("out_rnd", 64'(out_rnd), 64'(e.rnd));
          end
          chk("done_busy", 64'(busy), 64'd1);
          chk("done_in_ready", 64'(in_ready), 64'd0);
          if (out_ready) begin
            expect_idle = 1;
            have_e = 0;
            if (b2b) begin
              hs_pending = 1;
              hs_edge = cyc + 1;
            end
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  task automatic scr();
    if (scramble) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_vec    = rand_x();
      out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic offer(input logic [IW-1:0] x);
    int   t = 0;
    logic ok = 1'b0;
    in_valid = 1'b1;
    in_vec   = x;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!ok && t < 50);
    if (!ok) fail("accept_timeout");
    in_valid = 1'b0;
    scr();
  endtask

  task automatic get_result(input int hold);
    int t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk);
      #1;
      t++;
      if (!out_valid) scr();
    end
    out_ready = 1'b0;
    if (!out_valid) begin
      fail("result_timeout");
      in_valid = 1'b0;
      return;
    end
    last_vec = out_vec;
    last_sat = out_sat;
    repeat (hold) begin
      scr();
      out_ready = 1'b0;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int acc0;
    reset_    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_vec    = '0;
    for (int n = 0; n < OUT; n++) wmem[n] = rand_w();
    #22;
    chk_reset();
    @(posedge clk);
    #1;
    reset_ = 1'b1;

    wmem[0] = 40'h05_01010101;
    wmem[1] = 40'h00_FFFFFFFF;
    wmem[2] = '0;
    offer(32'h04FDFE01);
    get_result(0);
    chk("nominal_vec", 64'(last_vec), 64'h000005);
    chk("nominal_sat", 64'(last_sat), 64'd0);

    for (int n = 0; n < OUT; n++) wmem[n] = rand_w();
    offer(rand_x());
    get_result(5);

    wmem[0] = 40'h7F7F7F7F7F;
    offer(32'h7F7F7F7F);
    get_result(1);
    chk("sat_vec0", 64'(last_vec[7:0]), 64'd127);
    chk("sat_flag0", 64'(last_sat[0]), 64'd1);

    scramble = 1;
    for (int k = 0; k < 20; k++) begin
      for (int n = 0; n < OUT; n++) wmem[n] = rand_w();
      offer(rand_x());
      get_result($urandom_range(0, 3));
    end
    scramble = 0;
    in_valid = 1'b0;
    out_ready = 1'b0;

    for (int n = 0; n < OUT; n++) wmem[n] = rand_w();
    offer(rand_x());
    t = 0;
    while (!(w_rd && w_addr == NW'(1)) && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 50) fail("fetch1_timeout");
    @(posedge clk);
    #1;
    reset_ = 1'b0;
    #1;
    chk_reset();
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    rel_edge = cyc;
    chk_rel  = 1;
    reset_   = 1'b1;
    offer(rand_x());
    get_result(0);
    chk("reset_accept_seen", 64'(chk_rel), 64'd0);

    for (int n = 0; n < OUT; n++) wmem[n] = rand_w();
    b2b   = 1;
    acc0  = n_acc;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    repeat (60) begin
      in_vec = rand_x();
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    t = 0;
    while ((busy || q.size() != 0) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("b2b_count", 64'(n_acc - acc0), 64'((60 - 1) / (3 * OUT + 2) + 1));
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    b2b = 0;
    hs_pending = 0;
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
